// File: rtl/div_sweep_pkg.sv
// Shared types and default sizes for the divider frequency-sweep controller.
package div_sweep_pkg;

  localparam int DEPTH   = 8;
  localparam int SEL_W   = 5;
  localparam int DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef struct packed {
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
  } entry_t;

endpackage

// File: rtl/div_sweep_ctrl_edge_sync.sv
// Brings the divider output into the clk domain and flags each rising edge.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  // NOTE: flops take non-blocking assignments so every stage samples its
  // predecessor's value from before the edge, giving a true shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/div_sweep_ctrl.sv
// Steps a divider through a table of frequency selects, holding each entry
// for a programmable number of divider edges, with stop and stall handling.
module div_sweep_ctrl #(
  parameter int DEPTH   = div_sweep_pkg::DEPTH,
  parameter int SEL_W   = div_sweep_pkg::SEL_W,
  parameter int DWELL_W = div_sweep_pkg::DWELL_W,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       mode_loop,
  input  logic [$clog2(DEPTH)-1:0]   len,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DWELL_W+SEL_W-1:0]   wr_data,
  input  logic                       div_clk,
  output logic [SEL_W-1:0]           f_select,
  output logic                       f_load,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic                       done,
  output logic                       stall
);

  import div_sweep_pkg::state_t, div_sweep_pkg::entry_t;
  import div_sweep_pkg::IDLE, div_sweep_pkg::LOAD, div_sweep_pkg::RUN;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t             state, state_next;
  entry_t             tbl [DEPTH];
  logic [IDX_W-1:0]   len_q;
  logic               loop_q;
  logic [DWELL_W-1:0] edge_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               rise, accept, term, last, tmo_hit;
  logic [IDX_W-1:0]   idx_inc;

  edge_sync u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (div_clk),
    .rise     (rise)
  );

  // Stop outranks start, and start is only heard while idle.
  assign accept  = (state == IDLE) && start && !stop;
  assign term    = (state == RUN) && rise && (edge_cnt == tbl[idx].dwell);
  assign last    = (idx == len_q);
  assign tmo_hit = (state == RUN) && !rise && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = stop ? IDLE : RUN;
      RUN: begin
        if (stop || (term && last && !loop_q) || tmo_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // NOTE: the table lives in flops and is cleared by reset, so a sweep after
  // reset reads known zeros rather than power-up garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      f_select <= '0;
      f_load   <= 1'b0;
      done     <= 1'b0;
      stall    <= 1'b0;
      idx      <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      edge_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      f_load <= 1'b0;
      done   <= 1'b0;

      if (state == IDLE && wr_en) tbl[wr_addr] <= wr_data;

      if (accept) begin
        len_q  <= len;
        loop_q <= mode_loop;
        stall  <= 1'b0;
        idx    <= '0;
      end

      if (state == LOAD && !stop) begin
        f_select <= tbl[0].sel;
        f_load   <= 1'b1;
        edge_cnt <= '0;
        tmo_cnt  <= '0;
      end

      if (state == RUN && !stop) begin
        if (rise) begin
          tmo_cnt <= '0;
          if (term) begin
            edge_cnt <= '0;
            if (!last) begin
              idx      <= idx_inc;
              f_select <= tbl[idx_inc].sel;
              f_load   <= 1'b1;
            end else if (loop_q) begin
              idx      <= '0;
              f_select <= tbl[0].sel;
              f_load   <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end else if (tmo_hit) begin
          stall <= 1'b1;
        end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_sweep_ctrl.sv
// Scoreboard bench: a table-level model predicts the f_load/done event stream.
module tb_div_sweep_ctrl;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset, start, stop, mode_loop, wr_en, div_clk;
  logic [2:0] len, wr_addr, idx;
  logic [8:0] wr_data;
  logic [4:0] f_select;
  logic       f_load, busy, done, stall;

  div_sweep_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode_loop (mode_loop),
    .len       (len),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .div_clk   (div_clk),
    .f_select  (f_select),
    .f_load    (f_load),
    .busy      (busy),
    .idx       (idx),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int sel;
    int idx;
    int edges;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   tsel[8], tdw[8];
  int   div_half = 50;
  bit   div_en = 1'b0;
  int   rise_total = 0, last_snap = 0;

  initial begin
    div_clk = 1'b0;
    #3;
    forever begin
      #(div_half);
      if (div_en) div_clk = ~div_clk;
      else        div_clk = 1'b0;
    end
  end

  always @(posedge div_clk) rise_total++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int   edges;
    exp_t e;
    if (reset === 1'b0 && (f_load === 1'b1 || done === 1'b1)) begin
      edges     = rise_total - last_snap;
      last_snap = rise_total;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event f_load=%0b done=%0b expected none", f_load, done);
      end else begin
        e = sb.pop_front();
        check("event_done", done, e.is_done);
        check("event_load", f_load, !e.is_done);
        if (e.is_done) begin
          check("done_busy", busy, 0);
          check("done_idx", idx, e.idx);
          check("done_f_select", f_select, e.sel);
        end else begin
          check("load_sel", f_select, e.sel);
          check("load_idx", idx, e.idx);
        end
        if (e.edges >= 0) check("dwell_edges", edges, e.edges);
      end
    end
  end

  // Each entry i is held for tdw[i]+1 divider edges; intervals touching the
  // sweep start are skipped because start is asynchronous to div_clk.
  task automatic push_sweep(input int l, input bit loop, input int passes);
    exp_t e;
    e = '{0, tsel[0], 0, -1};
    sb.push_back(e);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i <= l; i++) begin
        int ed;
        ed = (p == 0 && i == 0) ? -1 : tdw[i] + 1;
        if (i < l)      e = '{0, tsel[i+1], i + 1, ed};
        else if (loop)  e = '{0, tsel[0], 0, ed};
        else            e = '{1, tsel[l], l, ed};
        sb.push_back(e);
      end
    end
  endtask

  task automatic tbl_write(input int a, input int s, input int d, input bit model_update);
    @(posedge clk) #1;
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = {4'(d), 5'(s)};
    @(posedge clk) #1;
    wr_en = 1'b0;
    if (model_update) begin
      tsel[a] = s;
      tdw[a]  = d;
    end
  endtask

  task automatic pulse_start(input int l, input bit loop);
    @(posedge clk) #1;
    start     = 1'b1;
    len       = 3'(l);
    mode_loop = loop;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk) #1;
    stop = 1'b1;
    @(posedge clk) #1;
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_in_budget", n < budget, 1);
  endtask

  task automatic wait_sb(input int size, input int budget);
    int n = 0;
    while (sb.size() > size && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_events_in_budget", n < budget, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, l;
    bit lp;
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode_loop = 1'b0; len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) begin tsel[i] = 0; tdw[i] = 0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_f_select", f_select, 0);
    check("rst_f_load", f_load, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", idx, 0);
    check("rst_stall", stall, 0);

    // Directed table, one-shot.
    tbl_write(0, 3, 1, 1);
    tbl_write(1, 7, 0, 1);
    tbl_write(2, 12, 2, 1);
    div_half = 50;
    div_en   = 1'b1;
    push_sweep(2, 0, 1);
    pulse_start(2, 0);
    wait_idle(3000);
    repeat (5) @(negedge clk);
    check("oneshot_busy", busy, 0);
    check("oneshot_hold_sel", f_select, 12);

    // Loop mode: wraps back to entry 0 twice, then stopped.
    push_sweep(2, 1, 2);
    pulse_start(2, 1);
    wait_sb(0, 5000);
    pulse_stop();
    @(negedge clk);
    check("loop_stop_busy", busy, 0);
    check("loop_stop_idx", idx, 0);
    check("loop_stop_sel", f_select, 3);

    // Stop while entry 1 is active.
    push_sweep(2, 0, 1);
    pulse_start(2, 0);
    wait_sb(2, 3000);
    pulse_stop();
    @(negedge clk);
    check("stop1_busy", busy, 0);
    check("stop1_sel", f_select, 7);
    check("stop1_idx", idx, 1);
    repeat (40) @(negedge clk);
    sb.delete();

    // Start and stop together from idle.
    @(posedge clk) #1;
    start = 1'b1; stop = 1'b1; len = 3'd2; mode_loop = 1'b0;
    @(posedge clk) #1;
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check("start_stop_busy", busy, 0);

    // A write issued mid-sweep must not reach the table.
    push_sweep(2, 0, 1);
    pulse_start(2, 0);
    repeat (5) @(posedge clk);
    tbl_write(1, 31, 5, 0);
    wait_idle(3000);
    push_sweep(2, 0, 1);
    pulse_start(2, 0);
    wait_idle(3000);

    // Randomised tables, lengths, modes and divider rates.
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 8; a++) tbl_write(a, $urandom_range(0, 31), $urandom_range(0, 7), 1);
      div_half = $urandom_range(31, 69);
      l  = $urandom_range(0, 7);
      lp = 1'($urandom_range(0, 1));
      if (lp) begin
        push_sweep(l, 1, 2);
        pulse_start(l, 1);
        wait_sb(0, 20000);
        pulse_stop();
        @(negedge clk);
        check("rand_loop_stop_busy", busy, 0);
      end else begin
        push_sweep(l, 0, 1);
        pulse_start(l, 0);
        wait_idle(20000);
      end
    end

    // Divider held low: stall after TMO run cycles.
    div_en = 1'b0;
    repeat (10) @(posedge clk);
    begin
      exp_t e;
      e = '{0, tsel[0], 0, -1};
      sb.push_back(e);
    end
    pulse_start(0, 0);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
    end
    check("stall_busy_cycles", cnt, TMO + 1);
    check("stall_flag", stall, 1);
    check("stall_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("stall_sticky", stall, 1);

    div_en = 1'b1;
    push_sweep(0, 0, 1);
    pulse_start(0, 0);
    @(negedge clk);
    check("stall_cleared_by_start", stall, 0);
    wait_idle(3000);

    // Asynchronous reset mid-sweep clears outputs and the table.
    push_sweep(7, 1, 3);
    pulse_start(7, 1);
    wait_sb(sb.size() - 3, 20000);
    @(posedge clk) #3;
    reset = 1'b1;
    #1;
    check("arst_f_select", f_select, 0);
    check("arst_f_load", f_load, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_idx", idx, 0);
    check("arst_stall", stall, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin tsel[i] = 0; tdw[i] = 0; end
    push_sweep(7, 0, 1);
    pulse_start(7, 0);
    wait_idle(5000);
    check("post_reset_sel", f_select, 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sweep_ctrl.md
DIV_SWEEP_CTRL -- requirements
Module: div_sweep_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of sweep-table entries.
REQ-002 Parameter SEL_W, default 5: divider frequency-select width.
REQ-003 Parameter DWELL_W, default 4: per-entry dwell-field width.
REQ-004 Parameter TIMEOUT, default 65535: clk cycles without a div_clk rising edge before stall.
REQ-005 Port clk  in  1: single clock; all state is in this domain.
REQ-006 Port reset  in  1: asynchronous, active-high reset.
REQ-007 Port start  in  1: one-cycle request to begin a sweep.
REQ-008 Port stop  in  1: one-cycle request to abort a sweep.
REQ-009 Port mode_loop  in  1: 1 = wrap continuously, 0 = one-shot; sampled on an accepted start.
REQ-010 Port len  in  3: index of last used entry (entries 0..len); sampled on an accepted start.
REQ-011 Port wr_en, wr_addr[2:0], wr_data[8:0]  in: table write; wr_data = {dwell[3:0], sel[4:0]}.
REQ-012 Port div_clk  in  1: divider clk_out, asynchronous to clk.
REQ-013 Port f_select  out  SEL_W: frequency select driven to the divider.
REQ-014 Port f_load  out  1: one-cycle pulse whenever f_select is updated.
REQ-015 Port busy  out  1; idx  out  3: current entry index.
REQ-016 Port done  out  1: one-cycle pulse at one-shot completion; stall  out  1: sticky timeout flag.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD and RUN.
REQ-018 In IDLE, a write with wr_en=1 SHALL set table[wr_addr] <= wr_data on the next edge; writes SHALL be ignored while busy=1.
REQ-019 In IDLE, start=1 SHALL latch len and mode_loop, clear stall and idx, and enter LOAD.
REQ-020 LOAD SHALL last exactly 1 cycle: f_select <= table[0].sel, f_load=1, edge and timeout counters cleared; next state RUN.
REQ-021 busy SHALL be 1 in LOAD and RUN and 0 in IDLE.
REQ-022 div_clk SHALL pass through a 2-flop synchronizer plus a delay flop; rise = s2 & ~s3, giving 3 clk of latency.
REQ-023 In RUN, each rise SHALL increment the edge counter and clear the timeout counter.
REQ-024 The terminal condition SHALL be a rise when edge count == table[idx].dwell, i.e. each entry is held for dwell+1 rising edges.
REQ-025 On the terminal condition with idx<len: idx+1, f_select <= table[idx+1].sel and f_load=1 in the same cycle, and the edge counter cleared.
REQ-026 On the terminal condition with idx==len and mode_loop=1: idx wraps to 0, f_select <= table[0].sel, f_load=1.
REQ-027 On the terminal condition with idx==len and mode_loop=0: done=1 for 1 cycle, next state IDLE, f_select holds its last value, no f_load.
REQ-028 stop=1 in LOAD or RUN SHALL return the FSM to IDLE next cycle with f_select and idx held and no done.
REQ-029 If start and stop are asserted in the same cycle, stop SHALL win; start while busy SHALL be ignored.
REQ-030 In RUN, the timeout counter SHALL saturate; on reaching TIMEOUT, stall<=1 and the FSM enters IDLE with no done.
REQ-031 stall SHALL hold until the next accepted start or reset.
REQ-032 len=0 SHALL sweep the single entry 0; dwell=0 SHALL mean one edge per entry.

Reset
REQ-033 On reset: FSM=IDLE, f_select=0, f_load=0, busy=0, done=0, idx=0, stall=0, all table entries=0, and all counters and synchronizer flops=0.
REQ-034 Reset asserted mid-sweep SHALL take effect immediately and asynchronously; no done or f_load pulse SHALL be generated.

Structure
REQ-035 Package div_sweep_pkg SHALL hold the state enum, the SEL_W/DWELL_W/DEPTH constants and the table-entry struct {dwell, sel}.
REQ-036 Sub-module edge_sync SHALL contain the synchronizer and rise detector; the table SHALL be flops, not a RAM macro.

Verification
REQ-037 Table {sel=3,dw=1},{sel=7,dw=0},{sel=12,dw=2}, len=2, loop=0, div_clk period 10 clk, start -> f_select 3 (2 edges) -> 7 (1 edge) -> 12 (3 edges); done one cycle after the 6th rise+3; busy=0; f_select stays 12.
REQ-038 Same table with loop=1 -> after the 12 dwell, idx=0, f_select=3, f_load pulse, no done; sweep continues.
REQ-039 Stop asserted during entry 1 -> busy=0 next cycle, f_select=7, idx=1, done=0.
REQ-040 start and stop in the same cycle from IDLE -> remains IDLE, busy=0; a wr_en during RUN to addr 1 -> table unchanged after the sweep.
REQ-041 div_clk held low with TIMEOUT=100 -> stall=1 and busy=0 after 100 RUN cycles; next start clears stall.
REQ-042 Reset asserted mid-RUN -> all outputs zero asynchronously; read-back sweep after release shows the table cleared (f_select=0).
